// File: rtl/combat_pkg.sv
`default_nettype none
// ============================================================================
// combat_pkg : shared action encoding, limits, winner codes and FSM states
// Revision   : 1.0
// ============================================================================
package combat_pkg;

    localparam int WALK   = 0;
    localparam int CROUCH = 1;
    localparam int SHIELD = 2;
    localparam int JUMP   = 3;
    localparam int PUNCH  = 4;
    localparam int STAND  = 5;
    localparam int DIR    = 6;

    localparam logic [7:0] MAX_HEALTH = 8'd100;
    localparam logic [7:0] MAX_SHIELD = 8'd100;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [0:0] {
        FIGHT = 1'b0,
        KO    = 1'b1
    } state_t;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/combat_hit_check.sv
`default_nettype none
// ============================================================================
// combat_hit_check : punch edge detect plus registered reach/dodge check
// Revision         : 1.0
// ============================================================================
module combat_hit_check
    import combat_pkg::*;
#(
    parameter int PUNCH_RANGE = 64,
    parameter int Y_TOL       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] attacker_action,
    input  logic [9:0] attacker_x,
    input  logic [9:0] attacker_y,
    input  logic [6:0] target_action,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       target_invuln,
    output logic       hit_valid,
    output logic       target_shielding,
    output logic       target_crouching
);

    localparam logic signed [10:0] RANGE = 11'(PUNCH_RANGE);
    localparam logic        [9:0]  YTOL  = 10'(Y_TOL);

    logic              punch_q;
    logic              punch_qq;
    logic              attack;
    logic signed [10:0] dx;
    logic        [9:0] dy;
    logic              in_x;
    logic              in_y;
    logic              unused_action_bits;

    assign attack = punch_q & ~punch_qq;
    assign dx     = $signed({1'b0, target_x}) - $signed({1'b0, attacker_x});
    assign dy     = (target_y >= attacker_y) ? (target_y - attacker_y) : (attacker_y - target_y);

    // Facing left reaches only targets strictly to the left; dx==0 never lands.
    assign in_x = attacker_action[DIR] ? ((dx < 11'sd0) && (dx >= -RANGE))
                                       : ((dx > 11'sd0) && (dx <= RANGE));
    assign in_y = (dy <= YTOL);

    assign unused_action_bits = ^{attacker_action[STAND], attacker_action[JUMP],
                                  attacker_action[SHIELD], attacker_action[CROUCH],
                                  attacker_action[WALK], target_action[DIR],
                                  target_action[STAND], target_action[PUNCH],
                                  target_action[WALK]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            punch_q          <= 1'b0;
            punch_qq         <= 1'b0;
            hit_valid        <= 1'b0;
            target_shielding <= 1'b0;
            target_crouching <= 1'b0;
        end else begin
            punch_q          <= attacker_action[PUNCH];
            punch_qq         <= punch_q;
            hit_valid        <= attack & in_x & in_y & ~target_action[JUMP] & ~target_invuln;
            target_shielding <= target_action[SHIELD];
            target_crouching <= target_action[CROUCH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
// combat_resolver : resolves punches into health/shield, owns KO and winner
// Revision        : 1.0
// ============================================================================
module combat_resolver
    import combat_pkg::*;
#(
    parameter int PUNCH_RANGE   = 64,
    parameter int Y_TOL         = 32,
    parameter int PUNCH_DMG     = 10,
    parameter int SHIELD_COST   = 20,
    parameter int REGEN_CYCLES  = 2500000,
    parameter int INVULN_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] p0_action,
    input  logic [9:0] p0_x,
    input  logic [9:0] p0_y,
    input  logic [6:0] p1_action,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    output logic [7:0] p0_health,
    output logic [7:0] p1_health,
    output logic [7:0] p0_shield,
    output logic [7:0] p1_shield,
    output logic       p0_hit,
    output logic       p1_hit,
    output logic       p0_blocked,
    output logic       p1_blocked,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int              RW          = $clog2(REGEN_CYCLES + 1);
    localparam int              IW          = $clog2(INVULN_CYCLES + 1);
    localparam logic [RW-1:0]   REGEN_LAST  = RW'(REGEN_CYCLES - 1);
    localparam logic [IW-1:0]   INVULN_LOAD = IW'(INVULN_CYCLES);
    localparam logic [7:0]      DMG_FULL    = 8'(PUNCH_DMG);
    localparam logic [7:0]      DMG_HALF    = 8'(PUNCH_DMG / 2);
    localparam logic [7:0]      COST        = 8'(SHIELD_COST);

    // All per-player arrays are indexed by the player being hit.
    logic [6:0]    action    [2];
    logic [9:0]    pos_x     [2];
    logic [9:0]    pos_y     [2];
    logic [7:0]    health    [2];
    logic [7:0]    shield    [2];
    logic [RW-1:0] regen_cnt [2];
    logic [IW-1:0] invuln    [2];
    logic [1:0]    hit;
    logic [1:0]    blocked;
    logic [1:0]    valid;
    logic [1:0]    tgt_shield;
    logic [1:0]    tgt_crouch;
    logic          live;
    state_t        state;

    assign action[0] = p0_action;
    assign action[1] = p1_action;
    assign pos_x[0]  = p0_x;
    assign pos_x[1]  = p1_x;
    assign pos_y[0]  = p0_y;
    assign pos_y[1]  = p1_y;

    generate
        for (genvar a = 0; a < 2; a++) begin : g_hit
            combat_hit_check #(
                .PUNCH_RANGE (PUNCH_RANGE),
                .Y_TOL       (Y_TOL)
            ) u_hit (
                .clk              (clk),
                .reset            (reset),
                .attacker_action  (action[a]),
                .attacker_x       (pos_x[a]),
                .attacker_y       (pos_y[a]),
                .target_action    (action[1-a]),
                .target_x         (pos_x[1-a]),
                .target_y         (pos_y[1-a]),
                .target_invuln    (invuln[1-a] != '0),
                .hit_valid        (valid[1-a]),
                .target_shielding (tgt_shield[1-a]),
                .target_crouching (tgt_crouch[1-a])
            );
        end
    endgenerate

    // Gate on health too, so nothing lands in the cycle between a KO hit and the state change.
    assign live = (state == FIGHT) && (health[0] != 8'd0) && (health[1] != 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FIGHT;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
            hit       <= 2'b00;
            blocked   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                health[i]    <= MAX_HEALTH;
                shield[i]    <= MAX_SHIELD;
                regen_cnt[i] <= '0;
                invuln[i]    <= '0;
            end
        end else begin
            for (int t = 0; t < 2; t++) begin
                hit[t]     <= 1'b0;
                blocked[t] <= 1'b0;
                if (live) begin
                    if (invuln[t] != '0)
                        invuln[t] <= invuln[t] - 1'b1;
                    if (action[t][SHIELD])
                        regen_cnt[t] <= '0;
                    else if (regen_cnt[t] == REGEN_LAST) begin
                        regen_cnt[t] <= '0;
                        if (shield[t] < MAX_SHIELD)
                            shield[t] <= shield[t] + 8'd1;
                    end else
                        regen_cnt[t] <= regen_cnt[t] + 1'b1;
                    // Later assignments here override regen: a block always wins.
                    if (valid[t]) begin
                        if (tgt_shield[t] && (shield[t] >= COST)) begin
                            shield[t]    <= shield[t] - COST;
                            regen_cnt[t] <= '0;
                            blocked[t]   <= 1'b1;
                        end else begin
                            if (tgt_shield[t])
                                shield[t] <= 8'd0;
                            health[t] <= sat_sub(health[t], tgt_crouch[t] ? DMG_HALF : DMG_FULL);
                            hit[t]    <= 1'b1;
                            invuln[t] <= INVULN_LOAD;
                        end
                    end
                end
            end
            case (state)
                FIGHT: begin
                    if ((health[0] == 8'd0) || (health[1] == 8'd0)) begin
                        state     <= KO;
                        game_over <= 1'b1;
                        if ((health[0] == 8'd0) && (health[1] == 8'd0))
                            winner <= WIN_DRAW;
                        else if (health[1] == 8'd0)
                            winner <= WIN_P0;
                        else
                            winner <= WIN_P1;
                    end
                end
                KO:      state <= KO;
                default: state <= FIGHT;
            endcase
        end
    end

    assign p0_health  = health[0];
    assign p1_health  = health[1];
    assign p0_shield  = shield[0];
    assign p1_shield  = shield[1];
    assign p0_hit     = hit[0];
    assign p1_hit     = hit[1];
    assign p0_blocked = blocked[0];
    assign p1_blocked = blocked[1];

endmodule
`default_nettype wire

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
Arbiter that consumes both players' action/position outputs and resolves punches into health and shield changes. It is the authority for health and shield in the game. It also drives hit/block pulses for sprite flash and audio, and the KO/winner result for the screen controller. It sits between the two player instances and the renderer/game FSM.

Parameters:
PUNCH_RANGE, 64, max horizontal distance in pixels for a punch to land
Y_TOL, 32, max vertical offset in pixels for a punch to land
PUNCH_DMG, 10, health removed by an unblocked standing hit
SHIELD_COST, 20, shield removed by a blocked hit
REGEN_CYCLES, 2500000, clocks per +1 shield regen while not shielding
INVULN_CYCLES, 12500000, clocks a target is unhittable after taking health damage

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
p0_action  in  7  player 0 one-hot action; bit6 = facing left; bits5..0 = STANDING,PUNCHING,JUMPING,SHIELDING,CROUCHING,WALKING
p0_x, p0_y  in  10 each  player 0 position
p1_action  in  7  player 1 action, same encoding
p1_x, p1_y  in  10 each  player 1 position
p0_health, p1_health  out  8 each  current health, 0..100
p0_shield, p1_shield  out  8 each  current shield, 0..100
p0_hit, p1_hit  out  1 each  one-cycle pulse: that player lost health
p0_blocked, p1_blocked  out  1 each  one-cycle pulse: that player blocked a hit
game_over  out  1  high in KO state
winner  out  2  00 none, 01 p0 wins, 10 p1 wins, 11 draw

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: health=100, shield=100, all pulses 0, game_over=0, winner=00, edge registers cleared, invuln and regen counters 0, state FIGHT. Reset mid-punch aborts any in-flight pipeline stage.
- FSM: FIGHT -> KO when any health==0 after a stage-2 update. KO is terminal until reset. In KO, no punches resolve and no regen occurs; all outputs hold.
- Stage 0: register each action's PUNCHING bit. attack = bit4 & ~prev. Exactly one resolution per punch, however long PUNCHING stays high.
- Stage 1 (registered): geometry per attacker A on target T.
  - dx = T_x - A_x as an 11-bit signed value.
  - Facing right: requires 0 < dx <= PUNCH_RANGE. Facing left: requires -PUNCH_RANGE <= dx < 0. dx==0 misses.
  - |T_y - A_y| <= Y_TOL is also required.
  - Target JUMPING: miss.
  - Target invuln counter nonzero: miss.
- Stage 2 (registered): apply the outcome.
  - Target SHIELDING and shield >= SHIELD_COST: shield -= SHIELD_COST; blocked pulse; no health change; no invuln.
  - Target SHIELDING and shield < SHIELD_COST: shield = 0; full damage applies.
  - Damage: PUNCH_DMG, or PUNCH_DMG>>1 if target CROUCHING.
  - Health saturates at 0. Hit pulse fires, and the target invuln counter loads INVULN_CYCLES.
- Latency: rising PUNCHING sampled at edge N; health/shield/pulses change at edge N+2; game_over at N+3.
- Simultaneous punches (both rise on the same cycle): both resolve independently, using the target's action as sampled in stage 1. If both healths reach 0 on the same update: winner=11.
- Winner otherwise names the player with nonzero health.
- Regen: a per-player counter increments each cycle while the player is not SHIELDING. At REGEN_CYCLES-1 it wraps to 0 and shield += 1, saturating at 100. The counter clears while SHIELDING and on a block. A regen and a block on the same cycle: the block wins, no regen that cycle.
- Invuln counter decrements to 0 and never wraps.
- All arithmetic is unsigned 8-bit with explicit saturation; there is no wrap-around on health or shield.

Decomposition:
- Package combat_pkg:
  - action bit indices: DIR=6, WALK=0, CROUCH=1, SHIELD=2, JUMP=3, PUNCH=4, STAND=5
  - MAX_HEALTH=100, MAX_SHIELD=100
  - winner codes
  - FSM state encoding (FIGHT, KO)
- Sub-module combat_hit_check, instantiated twice (p0->p1, p1->p0): edge detect plus stage-1 geometry/dodge check. It outputs a registered hit_valid and target_shielding/target_crouching flags.
- The top level holds stage 2, the counters and the FSM.

Test Plan:
- p0 at (300,240) facing right, p1 at (340,240) standing. p0 PUNCHING high for 10 cycles -> single p1_hit at N+2, p1_health=90, p1_shield=100.
- Same setup with p1 SHIELDING -> p1_blocked pulse, p1_shield=80, p1_health=100. Repeat 5 punches spaced past invuln -> shield 0 on 5th block; 6th punch gives p1_health=90.
- p1 CROUCHING -> p1_health=95. p1 JUMPING -> no pulse, health 100. p0 facing left -> miss. dx=65 -> miss. dx=64 -> hit.
- Both face each other 40 px apart and punch on the same cycle -> both health 90, both hit pulses on the same cycle. Preload both at 10 (via 9 spaced hits, INVULN_CYCLES=4), then a simultaneous punch -> game_over=1, winner=11; further punches ignored.
- REGEN_CYCLES=4: after a block (shield 80), not shielding -> shield 81 after 4 cycles, 100 after 80 cycles, stays 100.
- Assert reset between stage 1 and stage 2 of a landing punch -> health 100, no hit pulse, state FIGHT.
